// File: rtl/gpio_ctrl.sv
// GPIO peripheral: WIDTH tri-state pads, synchronised inputs, atomic SET/CLR/TGL and level/edge interrupts.
// Optional input debounce filter with prescaler enabled by defining GPIO_DEBOUNCE_EN.
module gpio_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ss,
    input  logic             ttype,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             bdone,
    inout  wire  [WIDTH-1:0] gpio,
    output logic             irq
);
    localparam int WC_W = $clog2(SYNC_STAGES + 2);
    localparam logic [WC_W-1:0] WARM_END = WC_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] oe, out, irq_en, irq_type, irq_pol, irq_both, pend;
    logic [WIDTH-1:0] raw, s, f, prev, rise, fall, edge_ev, ev, w1c, wd;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WC_W-1:0]  warm_cnt;
    logic             we, warm;
    logic [31:0]      deb_rd;
    logic             unused_ok;

    function automatic logic [31:0] ext(input logic [WIDTH-1:0] v);
        ext = '0;
        ext[WIDTH-1:0] = v;
    endfunction

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign gpio[i] = oe[i] ? out[i] : 1'bz;
    end

    assign raw       = gpio;
    assign s         = sync_q[SYNC_STAGES-1];
    assign we        = ss && ttype;
    assign wd        = wdata[WIDTH-1:0];
    assign bdone     = 1'b1;
    assign irq       = |(pend & irq_en);
    assign unused_ok = ^{addr[31:8], wdata};

`ifdef GPIO_DEBOUNCE_EN
    logic [DEB_CNT_W-1:0] deb_div, deb_cnt;
    logic [WIDTH-1:0]     smp, f_q;
    logic                 tick;

    assign tick   = (deb_cnt == deb_div);
    assign f      = (deb_div == '0) ? s : f_q;
    assign deb_rd = 32'(deb_div);

    // A pin level is accepted only when two consecutive ticks saw the same value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_div <= '0;
            deb_cnt <= '0;
            smp     <= '0;
            f_q     <= '0;
        end else begin
            if (we && addr[7:0] == 8'h2C) begin
                deb_div <= wdata[DEB_CNT_W-1:0];
                deb_cnt <= '0;
            end else begin
                deb_cnt <= tick ? '0 : deb_cnt + 1'b1;
            end
            if (tick) begin
                smp <= s;
                f_q <= (s & ~(s ^ smp)) | (f_q & (s ^ smp));
            end
        end
    end
`else
    logic [DEB_CNT_W-1:0] deb_unused;
    assign deb_unused = '0;
    assign f          = s;
    assign deb_rd     = '0;
`endif

    assign warm    = (warm_cnt == WARM_END);
    assign rise    = f & ~prev;
    assign fall    = ~f & prev;
    assign edge_ev = (irq_both & (rise | fall)) | (~irq_both & ((irq_pol & rise) | (~irq_pol & fall)));
    assign ev      = ({WIDTH{warm}} & irq_type & edge_ev) | (~irq_type & ~(f ^ irq_pol));
    assign w1c     = (we && addr[7:0] == 8'h28) ? wd : '0;

    always_comb begin
        rdata = '0;
        case (addr[7:0])
            8'h00:   rdata = ext(f);
            8'h04:   rdata = ext(oe);
            8'h08:   rdata = ext(out);
            8'h18:   rdata = ext(irq_en);
            8'h1C:   rdata = ext(irq_type);
            8'h20:   rdata = ext(irq_pol);
            8'h24:   rdata = ext(irq_both);
            8'h28:   rdata = ext(pend);
            8'h2C:   rdata = deb_rd;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe       <= '0;
            out      <= '0;
            irq_en   <= '0;
            irq_type <= '0;
            irq_pol  <= '0;
            irq_both <= '0;
        end else if (we) begin
            case (addr[7:0])
                8'h04:   oe       <= wd;
                8'h08:   out      <= wd;
                8'h0C:   out      <= out | wd;
                8'h10:   out      <= out & ~wd;
                8'h14:   out      <= out ^ wd;
                8'h18:   irq_en   <= wd;
                8'h1C:   irq_type <= wd;
                8'h20:   irq_pol  <= wd;
                8'h24:   irq_both <= wd;
                default: ;
            endcase
        end
    end

    // Warm-up counter keeps edge detection off until the synchroniser has flushed reset zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            prev     <= '0;
            pend     <= '0;
            warm_cnt <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            prev <= f;
            pend <= ev | (pend & ~w1c);
            if (!warm) warm_cnt <= warm_cnt + 1'b1;
        end
    end
endmodule
